// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on input and output.
// Single-cycle ops register their result on the accepting edge.
// Multiply runs as WIDTH shift-add iterations, one per clock.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// - The producer holds its payload stable while valid && !ready.
// - Input side: the operands are latched on that edge, so they need not be
//   held afterwards.
// - Output side: C, the flags and out_valid stay stable while
//   out_valid && !out_ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake for A, B, SelOp
//   A, B              operands (B[SHW-1:0] is the shift amount)
//   SelOp             4-bit opcode
//   out_valid/out_ready output handshake for C and the flags
//   C                 result
//   flag_z/n/c/v      zero, negative, carry/borrow, overflow
//   busy              multiply in progress (high exactly while the FSM is in MUL)
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       SelOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             busy
);

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

   localparam logic [3:0] OP_NOT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SR1 = 4'h7;
   localparam logic [3:0] OP_SL1 = 4'h8, OP_SRL = 4'h9, OP_SLL = 4'hA, OP_SRA = 4'hB;
   localparam logic [3:0] OP_SLT = 4'hC;
   localparam int         MSB    = WIDTH - 1;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     c_q, c_d;
   logic                 z_q, z_d, n_q, n_d, fc_q, fc_d, fv_q, fv_d;
   logic                 ov_q, ov_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;

   logic [WIDTH:0]       add_w, sub_w;
   logic [SHW-1:0]       shamt;
   logic [WIDTH-1:0]     res;
   logic                 res_c, res_v;
   logic [2*WIDTH-1:0]   prod_next;
   logic                 accept;

   assign in_ready  = (state_q == ST_IDLE) && (!ov_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign busy      = (state_q == ST_MUL);
   assign out_valid = ov_q;
   assign C         = c_q;
   assign flag_z    = z_q;
   assign flag_n    = n_q;
   assign flag_c    = fc_q;
   assign flag_v    = fv_q;

   // Extra top bit captures carry (ADD) and borrow (SUB).
   assign add_w = {1'b0, A} + {1'b0, B};
   assign sub_w = {1'b0, A} - {1'b0, B};
   assign shamt = B[SHW-1:0];

   // Single-cycle datapath.
   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (SelOp)
         OP_NOT: res = ~A;
         OP_ADD: begin
            res   = add_w[WIDTH-1:0];
            res_c = add_w[WIDTH];
            res_v = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
         end
         OP_SUB: begin
            res   = sub_w[WIDTH-1:0];
            res_c = sub_w[WIDTH];
            res_v = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
         end
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_XOR: res = A ^ B;
         OP_SR1: res = A >> 1;
         OP_SL1: res = A << 1;
         OP_SRL: res = A >> shamt;
         OP_SLL: res = A << shamt;
         OP_SRA: res = $unsigned($signed(A) >>> shamt);
         OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         default: res = '0;  // MUL is handled by the FSM; 1101-1111 give zero
      endcase
   end

   // Next-state and register-load logic.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      z_d       = z_q;
      n_d       = n_q;
      fc_d      = fc_q;
      fv_d      = fv_q;
      ov_d      = ov_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

      if (ov_q && out_ready) ov_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (SelOp == OP_MUL) begin
                  state_d  = ST_MUL;
                  prod_d   = '0;
                  mcand_d  = {{WIDTH{1'b0}}, A};
                  mplier_d = B;
                  cnt_d    = '0;
               end else begin
                  c_d  = res;
                  z_d  = (res == '0);
                  n_d  = res[MSB];
                  fc_d = res_c;
                  fv_d = res_v;
                  ov_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            // Add the shifted multiplicand when the current multiplier bit is set.
            prod_d   = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               c_d     = prod_next[WIDTH-1:0];
               z_d     = (prod_next[WIDTH-1:0] == '0);
               n_d     = prod_next[MSB];
               fc_d    = 1'b0;
               fv_d    = |prod_next[2*WIDTH-1:WIDTH];
               ov_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         c_q      <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         fc_q     <= 1'b0;
         fv_q     <= 1'b0;
         ov_q     <= 1'b0;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         z_q      <= z_d;
         n_q      <= n_d;
         fc_q     <= fc_d;
         fv_q     <= fv_d;
         ov_q     <= ov_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

   logic clk;
   logic rst_n;

   // 32-bit instance
   logic        iv32, ir32, ov32, or32, z32, n32, c32f, v32, busy32;
   logic [31:0] a32, b32, c32;
   logic [3:0]  op32;

   // 8-bit instance
   logic        iv8, ir8, ov8, or8, z8, n8, c8f, v8, busy8;
   logic [7:0]  a8, b8, c8;
   logic [3:0]  op8;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        z;
      logic        n;
      logic        fc;
      logic        fv;
   } vec_t;

   vec_t vecs[15];

   alu_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
      .A(a32), .B(b32), .SelOp(op32), .out_valid(ov32), .out_ready(or32),
      .C(c32), .flag_z(z32), .flag_n(n32), .flag_c(c32f), .flag_v(v32),
      .busy(busy32)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .A(a8), .B(b8), .SelOp(op8), .out_valid(ov8), .out_ready(or8),
      .C(c8), .flag_z(z8), .flag_n(n8), .flag_c(c8f), .flag_v(v8),
      .busy(busy8)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_flags32(input string name, input logic z, input logic n,
                              input logic fc, input logic fv);
      chk({name, ".z"}, z32, z);
      chk({name, ".n"}, n32, n);
      chk({name, ".c"}, c32f, fc);
      chk({name, ".v"}, v32, fv);
   endtask

   // driver: present one op on the 32-bit instance; leaves in_valid low after the edge
   task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
      @(posedge clk);
      #1;
      iv32 = 1'b0;
      a32  = $urandom;
      b32  = $urandom;
   endtask

   task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
      @(posedge clk);
      #1;
      iv8 = 1'b0;
      a8  = 8'($urandom_range(0, 255));
      b8  = 8'($urandom_range(0, 255));
      op8 = 4'($urandom_range(0, 15));
   endtask

   // Run one 8-bit multiply and check busy/in_ready over all WIDTH iterations.
   task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_c, input logic exp_v);
      issue8(4'h3, a, b);
      chk("mul_busy_e", busy8, 1'b1);
      chk("mul_ready_e", ir8, 1'b0);
      for (int k = 1; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (busy8 !== 1'b1 || ir8 !== 1'b0 || ov8 !== 1'b0)
            chk($sformatf("mul_iter%0d", k), {busy8, ir8, ov8}, 3'b100);
      end
      @(posedge clk);
      #1;
      chk("mul_out_valid", ov8, 1'b1);
      chk("mul_c", c8, exp_c);
      chk("mul_v", v8, exp_v);
      chk("mul_carry", c8f, 1'b0);
      chk("mul_busy_done", busy8, 1'b0);
   endtask

   initial begin
      vecs[0]  = '{"add_wrap",  4'h1, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 1, 0};
      vecs[1]  = '{"sub_ovf",   4'h2, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 0, 0, 1};
      vecs[2]  = '{"sub_brw",   4'h2, 32'h1,         32'h2,         32'hFFFF_FFFF, 0, 1, 1, 0};
      vecs[3]  = '{"sra",       4'hB, 32'h8000_0000, 32'h4,         32'hF800_0000, 0, 1, 0, 0};
      vecs[4]  = '{"srl",       4'h9, 32'h8000_0000, 32'h4,         32'h0800_0000, 0, 0, 0, 0};
      vecs[5]  = '{"slt_neg",   4'hC, 32'hFFFF_FFFF, 32'h0,         32'h1,         0, 0, 0, 0};
      vecs[6]  = '{"sr1",       4'h7, 32'h6,         32'h0,         32'h3,         0, 0, 0, 0};
      vecs[7]  = '{"not",       4'h0, 32'h0,         32'h0,         32'hFFFF_FFFF, 0, 1, 0, 0};
      vecs[8]  = '{"sl1",       4'h8, 32'h8000_0001, 32'h0,         32'h2,         0, 0, 0, 0};
      vecs[9]  = '{"sll_mask",  4'hA, 32'h1,         32'h3F,        32'h8000_0000, 0, 1, 0, 0};
      vecs[10] = '{"xor",       4'h6, 32'hF0F0,      32'hFF00,      32'h0FF0,      0, 0, 0, 0};
      vecs[11] = '{"or",        4'h5, 32'hF0,        32'h0F,        32'hFF,        0, 0, 0, 0};
      vecs[12] = '{"add_ovf",   4'h1, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0, 1};
      vecs[13] = '{"op_1101",   4'hD, 32'h5,         32'h5,         32'h0,         1, 0, 0, 0};
      vecs[14] = '{"slt_pos",   4'hC, 32'h0,         32'hFFFF_FFFF, 32'h0,         1, 0, 0, 0};

      rst_n = 1'b0;
      iv32 = 0; a32 = 0; b32 = 0; op32 = 0; or32 = 1;
      iv8  = 0; a8  = 0; b8  = 0; op8  = 0; or8  = 1;
      #23;
      // reset state
      chk("rst_valid", ov32, 1'b0);
      chk("rst_c", c32, 32'h0);
      chk_flags32("rst", 0, 0, 0, 0);
      chk("rst_busy", busy32, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", ir32, 1'b1);

      // table-driven single-cycle ops, out_ready held high
      for (int i = 0; i < 15; i++) begin
         issue32(vecs[i].op, vecs[i].a, vecs[i].b);
         chk({vecs[i].name, ".valid"}, ov32, 1'b1);
         chk({vecs[i].name, ".c"}, c32, vecs[i].c);
         chk_flags32(vecs[i].name, vecs[i].z, vecs[i].n, vecs[i].fc, vecs[i].fv);
      end
      @(posedge clk);
      #1;
      chk("valid_drops", ov32, 1'b0);

      // iterative multiply on the 8-bit instance
      mul8(8'h10, 8'h11, 8'h10, 1'b1);
      mul8(8'h03, 8'h05, 8'h0F, 1'b0);
      mul8(8'hFF, 8'hFF, 8'h01, 1'b1);

      // back-pressure: result held, then replaced with no bubble
      or32 = 1'b0;
      issue32(4'h1, 32'd2, 32'd3);
      chk("bp_valid", ov32, 1'b1);
      chk("bp_c", c32, 32'd5);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold_c%0d", k), c32, 32'd5);
         chk($sformatf("bp_hold_v%0d", k), ov32, 1'b1);
         chk($sformatf("bp_hold_rdy%0d", k), ir32, 1'b0);
      end
      @(negedge clk);
      op32 = 4'h4; a32 = 32'hF0; b32 = 32'h3C; iv32 = 1'b1; or32 = 1'b1;
      #1;
      chk("bp_in_ready", ir32, 1'b1);
      @(posedge clk);
      #1;
      iv32 = 1'b0;
      chk("bp_new_valid", ov32, 1'b1);
      chk("bp_new_c", c32, 32'h30);
      @(posedge clk);
      #1;
      chk("bp_drop", ov32, 1'b0);

      // reset during a multiply aborts it
      issue8(4'h3, 8'hFF, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy_pre", busy8, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy8, 1'b0);
      chk("abort_valid", ov8, 1'b0);
      chk("abort_c", c8, 8'h0);
      chk("abort_flags", {z8, n8, c8f, v8}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_in_ready", ir8, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (ov8 !== 1'b0) chk("abort_stale_valid", ov8, 1'b0);
      end
      issue8(4'hF, 8'h12, 8'h34);
      chk("op1111_valid", ov8, 1'b1);
      chk("op1111_c", c8, 8'h0);
      chk("op1111_flags", {z8, n8, c8f, v8}, 4'b1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
